// File: rtl/load_store_unit_pkg.sv
// MemoryModes: memory-port access modes, lsuOp encoding and op decode helpers
//   shared by load_store_unit and lsu_merge; no ports
package MemoryModes;
  typedef enum logic [2:0] {NONE, BYTE, HALFWORD, WORD, WORDLEFT, WORDRIGHT} readWriteModes;
  typedef enum logic [3:0] {LB, LBU, LH, LHU, LW, LWL, LWR, SB, SH, SW, SWL, SWR} lsuOp;
  function automatic readWriteModes op_mode(input logic [3:0] op);
    case (op)
      LB, LBU, SB: op_mode = BYTE;
      LH, LHU, SH: op_mode = HALFWORD;
      LW, SW:      op_mode = WORD;
      LWL, SWL:    op_mode = WORDLEFT;
      LWR, SWR:    op_mode = WORDRIGHT;
      default:     op_mode = NONE;
    endcase
  endfunction
  function automatic logic is_store(input logic [3:0] op);
    return op inside {SB, SH, SW, SWL, SWR};
  endfunction
  function automatic logic misaligned(input logic [3:0] op, input logic [1:0] a);
    return (op inside {LH, LHU, SH} && a[0]) || (op inside {LW, SW} && a != 2'b00);
  endfunction
endpackage

// File: rtl/load_store_unit_merge.sv
// lsu_merge: merges LWL/LWR partial memory data into the old rt value
//   mode: read mode; addr: byte offset; mem_rdata, rt_old: sources; result: merged word
module lsu_merge import MemoryModes::*; (
  input  logic [2:0]  mode,
  input  logic [1:0]  addr,
  input  logic [31:0] mem_rdata,
  input  logic [31:0] rt_old,
  output logic [31:0] result
);
  logic [31:0] m;
  // LWL keeps addr+1 top bytes (shift by 3-addr == ~addr), LWR keeps 4-addr bottom bytes
  assign m = mode == WORDLEFT  ? 32'hFFFF_FFFF << {~addr, 3'b000} :
             mode == WORDRIGHT ? 32'hFFFF_FFFF >> {addr, 3'b000} : 32'hFFFF_FFFF;
  assign result = (mem_rdata & m) | (rt_old & ~m);
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding CPU load/store sequencer in front of a combinational memory port
//   req_*: request handshake (op, addr, wdata, rt_old); resp_*: response handshake (rdata, err)
//   err_count: saturating misaligned-request count; mem_*: memory port, active only in ISSUE
module load_store_unit import MemoryModes::*; #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [3:0]           req_op,
  input  logic [31:0]          req_addr,
  input  logic [31:0]          req_wdata,
  input  logic [31:0]          req_rt_old,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [31:0]          resp_rdata,
  output logic                 resp_err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [31:0]          mem_address,
  output logic [31:0]          mem_data,
  output logic [2:0]           mem_write_mode,
  output logic [2:0]           mem_read_mode,
  output logic                 mem_unsigned_load,
  input  logic [31:0]          mem_rdata
);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2;
  logic [1:0] state;
  logic [3:0] op;
  logic [31:0] addr, wdata, rt_old, rdata, merged;
  logic err, issue, mis;
  assign issue = state == ISSUE;
  assign mis = misaligned(req_op, req_addr[1:0]);
  assign req_ready = state == IDLE;
  assign resp_valid = state == RESP;
  assign resp_rdata = rdata;
  assign resp_err = err;
  // port outputs are gated by state so reset or leaving ISSUE drops them at once
  assign mem_address = issue ? addr : '0;
  assign mem_data = issue ? wdata : '0;
  assign mem_write_mode = issue && is_store(op) ? op_mode(op) : NONE;
  assign mem_read_mode = issue && !is_store(op) ? op_mode(op) : NONE;
  assign mem_unsigned_load = issue && (op == LBU || op == LHU);
  lsu_merge u_merge (
    .mode(mem_read_mode),
    .addr(addr[1:0]),
    .mem_rdata(mem_rdata),
    .rt_old(rt_old),
    .result(merged)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      op <= '0;
      addr <= '0;
      wdata <= '0;
      rt_old <= '0;
      rdata <= '0;
      err <= 1'b0;
      err_count <= '0;
    end else if (state == IDLE) begin
      if (req_valid) begin
        op <= req_op;
        addr <= req_addr;
        wdata <= req_wdata;
        rt_old <= req_rt_old;
        rdata <= '0;
        err <= mis;
        state <= mis ? RESP : ISSUE;
        if (mis && ~&err_count) err_count <= err_count + 1'b1;
      end
    end else if (issue) begin
      rdata <= is_store(op) ? '0 : merged;
      state <= RESP;
    end else if (resp_ready)
      state <= IDLE;
endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  import MemoryModes::*;
  logic clk = 0;
  logic rst = 1;
  logic req_valid = 0;
  logic req_ready;
  logic [3:0] req_op = 0;
  logic [31:0] req_addr = 0, req_wdata = 0, req_rt_old = 0;
  logic resp_valid;
  logic resp_ready = 0;
  logic [31:0] resp_rdata;
  logic resp_err;
  logic [7:0] err_count;
  logic [31:0] mem_address, mem_data, mem_rdata;
  logic [2:0] mem_write_mode, mem_read_mode;
  logic mem_unsigned_load;
  logic [7:0] mem [0:4095];
  logic [7:0] ref_mem [0:4095];
  int checks = 0, errors = 0, writes = 0, exp_errs = 0;
  logic [11:0] dev_base;
  logic [31:0] dev_word;

  load_store_unit #(.ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rt_old(req_rt_old),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .err_count(err_count),
    .mem_address(mem_address), .mem_data(mem_data), .mem_write_mode(mem_write_mode),
    .mem_read_mode(mem_read_mode), .mem_unsigned_load(mem_unsigned_load), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // memory device: little-endian, combinational read, write on clock edge
  function automatic logic [31:0] dev_read(input logic [2:0] m, input logic [1:0] a, input logic [31:0] w, input logic u);
    logic [31:0] s;
    s = w >> (8 * a);
    case (m)
      BYTE:      return u ? {24'b0, s[7:0]} : {{24{s[7]}}, s[7:0]};
      HALFWORD:  return u ? {16'b0, s[15:0]} : {{16{s[15]}}, s[15:0]};
      WORD:      return w;
      WORDLEFT:  return w << (8 * (3 - a));
      WORDRIGHT: return s;
      default:   return 32'b0;
    endcase
  endfunction

  assign dev_base = {mem_address[11:2], 2'b00};
  assign dev_word = {mem[dev_base + 12'd3], mem[dev_base + 12'd2], mem[dev_base + 12'd1], mem[dev_base]};
  assign mem_rdata = dev_read(mem_read_mode, mem_address[1:0], dev_word, mem_unsigned_load);

  always @(posedge clk)
    if (mem_write_mode != NONE) begin
      writes <= writes + 1;
      case (mem_write_mode)
        BYTE: mem[mem_address[11:0]] <= mem_data[7:0];
        HALFWORD: begin
          mem[mem_address[11:0]] <= mem_data[7:0];
          mem[mem_address[11:0] + 12'd1] <= mem_data[15:8];
        end
        WORD: for (int i = 0; i < 4; i++) mem[dev_base + 12'(i)] <= mem_data[8*i +: 8];
        WORDLEFT: for (int i = 0; i < 4; i++)
          if (i <= int'(mem_address[1:0])) mem[dev_base + 12'(i)] <= mem_data[8*(3 - int'(mem_address[1:0]) + i) +: 8];
        WORDRIGHT: for (int i = 0; i < 4; i++)
          if (i >= int'(mem_address[1:0])) mem[dev_base + 12'(i)] <= mem_data[8*(i - int'(mem_address[1:0])) +: 8];
        default: ;
      endcase
    end

  // reference model: byte-addressed shadow memory and per-op semantics
  function automatic logic [7:0] rb(input logic [31:0] x);
    return ref_mem[x[11:0]];
  endfunction

  function automatic logic ref_mis(input logic [3:0] op, input logic [31:0] a);
    int sz;
    sz = (op == LH || op == LHU || op == SH) ? 2 : (op == LW || op == SW) ? 4 : 1;
    return (a % sz) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [3:0] op, input logic [31:0] a, input logic [31:0] rt);
    logic [31:0] r;
    logic [15:0] h;
    int k;
    k = int'(a % 4);
    h = {rb(a + 1), rb(a)};
    r = 32'b0;
    case (op)
      LB:  r = {{24{rb(a) >= 8'h80}}, rb(a)};
      LBU: r = {24'b0, rb(a)};
      LH:  r = {{16{h >= 16'h8000}}, h};
      LHU: r = {16'b0, h};
      LW:  r = {rb(a + 3), rb(a + 2), rb(a + 1), rb(a)};
      LWL: begin r = rt; for (int j = 0; j <= k; j++) r[8*(3 - j) +: 8] = rb(a - j); end
      LWR: begin r = rt; for (int j = 0; j <= 3 - k; j++) r[8*j +: 8] = rb(a + j); end
      default: r = 32'b0;
    endcase
    return r;
  endfunction

  task automatic ref_store(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd);
    int k;
    k = int'(a % 4);
    case (op)
      SB: ref_mem[a[11:0]] = wd[7:0];
      SH: for (int j = 0; j < 2; j++) ref_mem[12'(a + j)] = wd[8*j +: 8];
      SW: for (int j = 0; j < 4; j++) ref_mem[12'(a + j)] = wd[8*j +: 8];
      SWL: for (int j = 3 - k; j <= 3; j++) ref_mem[12'(a - (3 - j))] = wd[8*j +: 8];
      SWR: for (int j = 0; j <= 3 - k; j++) ref_mem[12'(a + j)] = wd[8*j +: 8];
      default: ;
    endcase
  endtask

  function automatic logic [31:0] dev_at(input logic [31:0] a);
    logic [11:0] b;
    b = {a[11:2], 2'b00};
    return {mem[b + 12'd3], mem[b + 12'd2], mem[b + 12'd1], mem[b]};
  endfunction

  function automatic logic [31:0] ref_at(input logic [31:0] a);
    logic [31:0] b;
    b = {a[31:2], 2'b00};
    return {rb(b + 3), rb(b + 2), rb(b + 1), rb(b)};
  endfunction

  // one request/response transaction, called and returning at posedge+1 with the unit idle
  task automatic xact(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rt,
                      input int hold, output logic [31:0] rd, output logic er, output int lat, output logic ok);
    ok = req_ready === 1'b1;
    req_op = op; req_addr = a; req_wdata = wd; req_rt_old = rt; req_valid = 1;
    @(posedge clk); #1;
    req_valid = 0;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 10) begin @(posedge clk); #1; lat++; end
    rd = resp_rdata; er = resp_err;
    if (req_ready !== 1'b0) ok = 0;
    repeat (hold) begin
      @(posedge clk); #1;
      if (resp_valid !== 1'b1 || resp_rdata !== rd || resp_err !== er || req_ready !== 1'b0) ok = 0;
    end
    resp_ready = 1;
    @(posedge clk); #1;
    resp_ready = 0;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) ok = 0;
  endtask

  task automatic test_reset();
    #1 rst = 0;
    #2;
    checks++;
    if ({req_ready, resp_valid, resp_err, mem_unsigned_load} !== 4'b1000) begin
      errors++; $display("FAIL reset_flags got %b want 1000", {req_ready, resp_valid, resp_err, mem_unsigned_load});
    end
    checks++;
    if (resp_rdata !== 32'b0 || err_count !== 8'b0) begin
      errors++; $display("FAIL reset_regs rdata %h err_count %0d want 0 0", resp_rdata, err_count);
    end
    checks++;
    if (mem_write_mode !== 3'b0 || mem_read_mode !== 3'b0 || mem_address !== 32'b0 || mem_data !== 32'b0) begin
      errors++; $display("FAIL reset_mem wm %0d rm %0d addr %h data %h want all 0", mem_write_mode, mem_read_mode, mem_address, mem_data);
    end
    @(posedge clk); #1;
    rst = 1;
    exp_errs = 0;
  endtask

  task automatic test_loads();
    logic [31:0] rd;
    logic er, ok;
    int lat;
    xact(SW, 32'h100, 32'h44332211, 0, 0, rd, er, lat, ok); ref_store(SW, 32'h100, 32'h44332211);
    xact(SB, 32'h200, 32'hFFFFFF80, 0, 0, rd, er, lat, ok); ref_store(SB, 32'h200, 32'hFFFFFF80);
    xact(LW, 32'h100, 0, 0, 0, rd, er, lat, ok);
    checks++; if (rd !== 32'h44332211) begin errors++; $display("FAIL lw rdata got %h want 44332211", rd); end
    checks++; if (lat !== 2 || er !== 1'b0) begin errors++; $display("FAIL lw latency %0d err %b want 2 0", lat, er); end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL lw handshake got %b want 1", ok); end
    xact(LWL, 32'h102, 0, 32'hAABBCCDD, 0, rd, er, lat, ok);
    checks++; if (rd !== 32'h332211DD) begin errors++; $display("FAIL lwl rdata got %h want 332211dd", rd); end
    xact(LWR, 32'h101, 0, 32'hAABBCCDD, 0, rd, er, lat, ok);
    checks++; if (rd !== 32'hAA443322) begin errors++; $display("FAIL lwr rdata got %h want aa443322", rd); end
    xact(LB, 32'h200, 0, 0, 0, rd, er, lat, ok);
    checks++; if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL lb rdata got %h want ffffff80", rd); end
    xact(LBU, 32'h200, 0, 0, 0, rd, er, lat, ok);
    checks++; if (rd !== 32'h00000080) begin errors++; $display("FAIL lbu rdata got %h want 00000080", rd); end
  endtask

  task automatic test_misaligned();
    logic [31:0] rd;
    logic er, ok;
    int lat, w0;
    xact(SW, 32'h300, 32'h12345678, 0, 0, rd, er, lat, ok); ref_store(SW, 32'h300, 32'h12345678);
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL err_count_start got %0d want 0", err_count); end
    w0 = writes;
    xact(SH, 32'h301, 32'hFFFF, 0, 0, rd, er, lat, ok);
    exp_errs++;
    checks++; if (er !== 1'b1 || lat !== 1) begin errors++; $display("FAIL sh_mis err %b latency %0d want 1 1", er, lat); end
    checks++; if (rd !== 32'b0) begin errors++; $display("FAIL sh_mis rdata got %h want 0", rd); end
    checks++; if (writes !== w0 || dev_at(32'h300) !== 32'h12345678) begin
      errors++; $display("FAIL sh_mis nowrite writes %0d word %h want %0d 12345678", writes, dev_at(32'h300), w0);
    end
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL err_count_one got %0d want 1", err_count); end
    xact(LW, 32'h102, 0, 0, 0, rd, er, lat, ok);
    exp_errs++;
    checks++; if (er !== 1'b1 || rd !== 32'b0) begin errors++; $display("FAIL lw_mis err %b rdata %h want 1 0", er, rd); end
    xact(LWL, 32'h103, 0, 32'h0, 0, rd, er, lat, ok);
    checks++; if (er !== 1'b0 || rd !== 32'h44332211) begin errors++; $display("FAIL lwl_103 err %b rdata %h want 0 44332211", er, rd); end
  endtask

  task automatic test_stall();
    logic [31:0] rd;
    logic er, ok;
    int lat;
    xact(SW, 32'h400, 32'hDEADBEEF, 0, 5, rd, er, lat, ok); ref_store(SW, 32'h400, 32'hDEADBEEF);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL stall_hold got %b want 1", ok); end
    checks++; if (rd !== 32'b0 || er !== 1'b0 || lat !== 2) begin
      errors++; $display("FAIL stall_sw rdata %h err %b latency %0d want 0 0 2", rd, er, lat);
    end
    xact(LW, 32'h400, 0, 0, 0, rd, er, lat, ok);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL stall_lw got %h want deadbeef", rd); end
  endtask

  task automatic test_reset_in_issue();
    logic [31:0] rd;
    logic er, ok;
    int lat;
    xact(SW, 32'h500, 32'h01020304, 0, 0, rd, er, lat, ok); ref_store(SW, 32'h500, 32'h01020304);
    req_op = SB; req_addr = 32'h500; req_wdata = 32'hAB; req_valid = 1;
    @(posedge clk); #1;
    req_valid = 0;
    checks++; if (mem_write_mode !== 3'(BYTE)) begin errors++; $display("FAIL issue_mode got %0d want %0d", mem_write_mode, BYTE); end
    rst = 0;
    #1;
    checks++; if (mem_write_mode !== 3'b0) begin errors++; $display("FAIL rst_issue_mode got %0d want 0", mem_write_mode); end
    @(posedge clk); #1;
    checks++; if (mem[12'h500] !== 8'h04) begin errors++; $display("FAIL rst_issue_mem got %h want 04", mem[12'h500]); end
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || err_count !== 8'd0) begin
      errors++; $display("FAIL rst_issue_state ready %b valid %b err_count %0d want 1 0 0", req_ready, resp_valid, err_count);
    end
    rst = 1;
    exp_errs = 0;
    @(posedge clk); #1;
    xact(LW, 32'h500, 0, 0, 0, rd, er, lat, ok);
    checks++; if (rd !== 32'h01020304) begin errors++; $display("FAIL after_rst_lw got %h want 01020304", rd); end
  endtask

  task automatic test_random();
    logic [31:0] rd, a, wd, rt, exp_rd;
    logic er, ok, exp_mis;
    logic [3:0] op;
    int lat;
    for (int i = 0; i < 64; i++) begin
      wd = $urandom;
      xact(SW, 32'h600 + 32'(4 * i), wd, 0, 0, rd, er, lat, ok);
      ref_store(SW, 32'h600 + 32'(4 * i), wd);
    end
    for (int i = 0; i < 300; i++) begin
      op = 4'($urandom_range(0, 11));
      a = 32'h600 + $urandom_range(0, 251);
      wd = $urandom;
      rt = $urandom;
      exp_mis = ref_mis(op, a);
      exp_rd = exp_mis ? 32'b0 : ref_load(op, a, rt);
      xact(op, a, wd, rt, $urandom_range(0, 2), rd, er, lat, ok);
      if (exp_mis) exp_errs = exp_errs < 255 ? exp_errs + 1 : 255;
      else ref_store(op, a, wd);
      checks++; if (rd !== exp_rd || er !== exp_mis) begin
        errors++; $display("FAIL rand op %0d addr %h rdata %h err %b want %h %b", op, a, rd, er, exp_rd, exp_mis);
      end
      checks++; if (lat !== (exp_mis ? 1 : 2) || ok !== 1'b1) begin
        errors++; $display("FAIL rand_timing op %0d addr %h latency %0d hold %b want %0d 1", op, a, lat, ok, exp_mis ? 1 : 2);
      end
      if (op >= SB) begin
        checks++; if (dev_at(a) !== ref_at(a)) begin
          errors++; $display("FAIL rand_mem op %0d addr %h word %h want %h", op, a, dev_at(a), ref_at(a));
        end
      end
    end
    checks++; if (err_count !== 8'(exp_errs)) begin errors++; $display("FAIL rand_err_count got %0d want %0d", err_count, exp_errs); end
  endtask

  task automatic test_saturation();
    logic [31:0] rd, a;
    logic er, ok;
    logic [3:0] op;
    int lat, sel;
    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 4);
      op = sel == 0 ? LH : sel == 1 ? LHU : sel == 2 ? SH : sel == 3 ? LW : SW;
      a = (sel < 3) ? 32'h700 + 32'(2 * $urandom_range(0, 100)) + 1 : 32'h700 + 32'(4 * $urandom_range(0, 50)) + $urandom_range(1, 3);
      xact(op, a, $urandom, $urandom, 0, rd, er, lat, ok);
      exp_errs = exp_errs < 255 ? exp_errs + 1 : 255;
      checks++; if (er !== 1'b1) begin errors++; $display("FAIL sat_err op %0d addr %h got %b want 1", op, a, er); end
    end
    checks++; if (err_count !== 8'hFF || exp_errs != 255) begin
      errors++; $display("FAIL sat_count got %0d want 255 (model %0d)", err_count, exp_errs);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    foreach (ref_mem[i]) ref_mem[i] = 8'h00;
    test_reset();
    test_loads();
    test_misaligned();
    test_stall();
    test_reset_in_issue();
    test_random();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
